// File: rtl/obi_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : obi_rr_arbiter_pkg
// Brief   : OBI channel types, configuration and index-width helper.
// Revision: 1.0 - initial release
// ============================================================================
package obi_rr_arbiter_pkg;

    localparam int unsigned c_addr_width = 32;
    localparam int unsigned c_data_width = 32;
    localparam int unsigned c_id_width   = 4;

    typedef struct packed {
        logic UseRReady;
        logic Integrity;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b0, Integrity: 1'b0};

    typedef struct packed {
        logic [c_addr_width-1:0]   addr;
        logic                      we;
        logic [c_data_width/8-1:0] be;
        logic [c_data_width-1:0]   wdata;
        logic [c_id_width-1:0]     aid;
        logic                      a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic [c_data_width-1:0] rdata;
        logic [c_id_width-1:0]   rid;
        logic                    err;
        logic                    r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    // A single manager still needs a 1-bit index so the FIFO has a data path.
    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/obi_arb_idx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : obi_arb_idx_fifo
// Brief   : Manager-index FIFO for in-order response routing (no fall-through).
// Revision: 1.0 - initial release
// ============================================================================
module obi_arb_idx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned c_ptr_width = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_cnt_width = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [c_ptr_width-1:0] r_wr_ptr;
    logic [c_ptr_width-1:0] r_rd_ptr;
    logic [c_cnt_width-1:0] r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    // Explicit compare-and-clear keeps non-power-of-two depths correct.
    function automatic logic [c_ptr_width-1:0] ptr_inc(input logic [c_ptr_width-1:0] p);
        return (p == c_ptr_width'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (r_count == c_cnt_width'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_comb begin
        head = r_mem[0];
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (r_rd_ptr == c_ptr_width'(k)) head = r_mem[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < int'(DEPTH); k++) r_mem[k] <= '0;
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (w_do_push && (r_wr_ptr == c_ptr_width'(k))) r_mem[k] <= data_in;
            end
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : obi_rr_arbiter
// Brief   : Round-robin N:1 OBI arbiter with grant lock and in-order R routing.
// Revision: 1.0 - initial release
// ============================================================================
module obi_rr_arbiter
    import obi_rr_arbiter_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg    = ObiDefaultConfig,
    parameter type         obi_req_t = obi_rr_arbiter_pkg::obi_req_t,
    parameter type         obi_rsp_t = obi_rr_arbiter_pkg::obi_rsp_t,
    parameter int unsigned NumMgr    = 4,
    parameter int unsigned MaxTrans  = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t sbr_req_i [NumMgr],
    output obi_rsp_t sbr_rsp_o [NumMgr],
    output obi_req_t mgr_req_o,
    input  obi_rsp_t mgr_rsp_i
);

    localparam int unsigned c_idx_width = idx_width(NumMgr);
    localparam int unsigned c_cnt_width = $clog2(MaxTrans + 1);

    logic [c_idx_width-1:0] r_rr;
    logic                   r_lock;
    logic [c_idx_width-1:0] r_lock_idx;

    logic [NumMgr-1:0]      w_req_vec;
    logic                   w_any_req;
    logic [c_idx_width-1:0] w_sel;
    logic [c_idx_width-1:0] w_head;
    logic                   w_head_rready;
    logic                   w_rready;
    logic                   w_mgr_req;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [c_cnt_width-1:0] w_fifo_count;
    logic                   w_unused_count;

    // Lowest offset from the round-robin pointer wins; the downward loop lets it overwrite.
    function automatic logic [c_idx_width-1:0] rr_pick(input logic [c_idx_width-1:0] start,
                                                       input logic [NumMgr-1:0]      reqs);
        rr_pick = start;
        for (int k = int'(NumMgr) - 1; k >= 0; k--) begin
            for (int j = 0; j < int'(NumMgr); j++) begin
                if (reqs[j] && (32'(j) == ((32'(start) + 32'(k)) % NumMgr))) begin
                    rr_pick = c_idx_width'(j);
                end
            end
        end
    endfunction

    always_comb begin
        w_req_vec     = '0;
        w_head_rready = 1'b0;
        for (int j = 0; j < int'(NumMgr); j++) begin
            w_req_vec[j] = sbr_req_i[j].req;
            if (w_head == c_idx_width'(j)) w_head_rready = sbr_req_i[j].rready;
        end
    end

    assign w_any_req = |w_req_vec;
    assign w_sel     = r_lock ? r_lock_idx : rr_pick(r_rr, w_req_vec);
    assign w_mgr_req = w_any_req && !w_full;
    assign w_push    = w_mgr_req && mgr_rsp_i.gnt;
    assign w_rready  = ObiCfg.UseRReady ? w_head_rready : 1'b1;
    // A stray rvalid with nothing outstanding is swallowed rather than popped.
    assign w_pop     = mgr_rsp_i.rvalid && !w_empty && w_rready;

    always_comb begin
        mgr_req_o = '0;
        for (int j = 0; j < int'(NumMgr); j++) begin
            if (w_sel == c_idx_width'(j)) mgr_req_o.a = sbr_req_i[j].a;
        end
        mgr_req_o.req    = w_mgr_req;
        mgr_req_o.rready = w_rready;
    end

    for (genvar i = 0; i < int'(NumMgr); i++) begin : g_rsp
        always_comb begin
            sbr_rsp_o[i]        = '0;
            sbr_rsp_o[i].r      = mgr_rsp_i.r;
            sbr_rsp_o[i].gnt    = w_push && (w_sel == c_idx_width'(i));
            sbr_rsp_o[i].rvalid = mgr_rsp_i.rvalid && !w_empty && (w_head == c_idx_width'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr       <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_push) begin
            r_rr   <= (w_sel == c_idx_width'(NumMgr - 1)) ? '0 : w_sel + 1'b1;
            r_lock <= 1'b0;
        end else if (w_mgr_req) begin
            r_lock     <= 1'b1;
            r_lock_idx <= w_sel;
        end
    end

    obi_arb_idx_fifo #(
        .DEPTH (MaxTrans),
        .WIDTH (c_idx_width)
    ) u_idx_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (w_push),
        .pop     (w_pop),
        .data_in (w_sel),
        .head    (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_fifo_count)
    );

    assign w_unused_count = ^w_fifo_count;

`ifdef OBI_ASSERT_ON
    if (NumMgr < 1 || MaxTrans < 1) begin : g_bad_param
        $error("obi_rr_arbiter: NumMgr and MaxTrans must be at least 1");
    end
    if (ObiCfg.Integrity) begin : g_no_integrity
        $error("obi_rr_arbiter: integrity signals are not supported");
    end
    for (genvar i = 0; i < int'(NumMgr); i++) begin : g_a_stable
        a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
            (sbr_req_i[i].req && !sbr_rsp_o[i].gnt) |=> $stable(sbr_req_i[i].a))
            else $error("A channel changed while waiting for grant");
    end
    no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && w_full)) else $error("push while full");
    no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mgr_rsp_i.rvalid && w_empty)) else $error("rvalid with no outstanding transaction");
`endif

endmodule
`default_nettype wire

// File: tb/tb_obi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_obi_rr_arbiter
// Brief   : Directed vector table plus a pointer-wrap sequence for obi_rr_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_obi_rr_arbiter;
    import obi_rr_arbiter_pkg::*;

    localparam obi_cfg_t c_cfg = '{UseRReady: 1'b1, Integrity: 1'b0};

    logic     clk = 1'b0;
    logic     rst_i = 1'b0;
    obi_req_t sbr_req [4];
    obi_rsp_t sbr_rsp [4];
    obi_req_t mgr_req;
    obi_rsp_t mgr_rsp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    obi_rr_arbiter #(
        .ObiCfg    (c_cfg),
        .obi_req_t (obi_req_t),
        .obi_rsp_t (obi_rsp_t),
        .NumMgr    (4),
        .MaxTrans  (4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .sbr_req_i (sbr_req),
        .sbr_rsp_o (sbr_rsp),
        .mgr_req_o (mgr_req),
        .mgr_rsp_i (mgr_rsp)
    );

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] rrdy;
        bit         gnt;
        bit         rv;
        bit         exp_req;
        int         exp_sel;
        logic [3:0] exp_gnt;
        logic [3:0] exp_rv;
        bit         exp_rrdy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit rst, logic [3:0] req, logic [3:0] rrdy, bit gnt, bit rv,
                                bit ereq, int sel, logic [3:0] eg, logic [3:0] er, bit errdy);
        vec_t v;
        v = '{rst, req, rrdy, gnt, rv, ereq, sel, eg, er, errdy};
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [3:0] gmask();
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = sbr_rsp[i].gnt;
        return m;
    endfunction

    function automatic logic [3:0] rvmask();
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = sbr_rsp[i].rvalid;
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) sbr_req[i].req = 1'b0;
        mgr_rsp.gnt    = 1'b0;
        mgr_rsp.rvalid = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] rrdy, input bit gnt,
                         input bit rv, input logic [31:0] rdata);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sbr_req[i].req    = req[i];
            sbr_req[i].rready = rrdy[i];
        end
        mgr_rsp.gnt     = gnt;
        mgr_rsp.rvalid  = rv;
        mgr_rsp.r.rdata = rdata;
        #2;
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [31:0] rd;
        rd = 32'hDEAD_BEEF ^ 32'(idx);
        if (v.rst) do_reset();
        drive(v.req, v.rrdy, v.gnt, v.rv, rd);
        chk("mgr_req", idx, 64'(mgr_req.req), 64'(v.exp_req));
        if (v.exp_req) begin
            chk("mgr_addr", idx, 64'(mgr_req.a.addr), 64'(32'h100 * (v.exp_sel + 1)));
            chk("mgr_aid", idx, 64'(mgr_req.a.aid), 64'(v.exp_sel));
        end
        chk("sbr_gnt", idx, 64'(gmask()), 64'(v.exp_gnt));
        chk("sbr_rvalid", idx, 64'(rvmask()), 64'(v.exp_rv));
        if (v.exp_rv != 4'b0000) begin
            chk("rdata0", idx, 64'(sbr_rsp[0].r.rdata), 64'(rd));
            chk("rdata3", idx, 64'(sbr_rsp[3].r.rdata), 64'(rd));
        end
        chk("mgr_rready", idx, 64'(mgr_req.rready), 64'(v.exp_rrdy));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            sbr_req[i]        = '0;
            sbr_req[i].a.addr = 32'h100 * (i + 1);
            sbr_req[i].a.aid  = 4'(i);
            sbr_req[i].a.we   = i[0];
            sbr_req[i].rready = 1'b1;
        end
        mgr_rsp = '0;

        //        rst  req    rrdy   g  rv  ereq sel egnt   erv    errdy
        vq.push_back(mk(1, 4'b0000, 4'hF, 0, 0, 0, 0, 4'b0000, 4'b0000, 1)); // reset state
        vq.push_back(mk(0, 4'b0001, 4'hF, 1, 0, 1, 0, 4'b0001, 4'b0000, 1)); // single manager
        vq.push_back(mk(0, 4'b0000, 4'hF, 1, 1, 0, 0, 4'b0000, 4'b0001, 1));
        vq.push_back(mk(1, 4'b1111, 4'hF, 1, 0, 1, 0, 4'b0001, 4'b0000, 1)); // round robin
        vq.push_back(mk(0, 4'b1111, 4'hF, 1, 1, 1, 1, 4'b0010, 4'b0001, 1));
        vq.push_back(mk(0, 4'b1111, 4'hF, 1, 1, 1, 2, 4'b0100, 4'b0010, 1));
        vq.push_back(mk(0, 4'b1111, 4'hF, 1, 1, 1, 3, 4'b1000, 4'b0100, 1));
        vq.push_back(mk(0, 4'b1111, 4'hF, 1, 1, 1, 0, 4'b0001, 4'b1000, 1));
        vq.push_back(mk(0, 4'b1111, 4'hF, 0, 1, 1, 1, 4'b0000, 4'b0001, 1));
        vq.push_back(mk(1, 4'b0100, 4'hF, 0, 0, 1, 2, 4'b0000, 4'b0000, 1)); // lock
        vq.push_back(mk(0, 4'b0101, 4'hF, 0, 0, 1, 2, 4'b0000, 4'b0000, 1));
        vq.push_back(mk(0, 4'b0101, 4'hF, 0, 0, 1, 2, 4'b0000, 4'b0000, 1));
        vq.push_back(mk(0, 4'b0101, 4'hF, 1, 0, 1, 2, 4'b0100, 4'b0000, 1));
        vq.push_back(mk(0, 4'b1001, 4'hF, 1, 1, 1, 3, 4'b1000, 4'b0100, 1));
        vq.push_back(mk(0, 4'b0001, 4'hF, 1, 1, 1, 0, 4'b0001, 4'b1000, 1));
        vq.push_back(mk(0, 4'b0000, 4'hF, 0, 1, 0, 0, 4'b0000, 4'b0001, 1));
        vq.push_back(mk(1, 4'b1111, 4'hF, 1, 0, 1, 0, 4'b0001, 4'b0000, 1)); // full
        vq.push_back(mk(0, 4'b1111, 4'hF, 1, 0, 1, 1, 4'b0010, 4'b0000, 1));
        vq.push_back(mk(0, 4'b1111, 4'hF, 1, 0, 1, 2, 4'b0100, 4'b0000, 1));
        vq.push_back(mk(0, 4'b1111, 4'hF, 1, 0, 1, 3, 4'b1000, 4'b0000, 1));
        vq.push_back(mk(0, 4'b1111, 4'hF, 1, 0, 0, 0, 4'b0000, 4'b0000, 1));
        vq.push_back(mk(0, 4'b1111, 4'hF, 1, 1, 0, 0, 4'b0000, 4'b0001, 1));
        vq.push_back(mk(0, 4'b1111, 4'hF, 1, 0, 1, 0, 4'b0001, 4'b0000, 1));
        vq.push_back(mk(1, 4'b1000, 4'hF, 1, 0, 1, 3, 4'b1000, 4'b0000, 1)); // out of order + rready
        vq.push_back(mk(0, 4'b0010, 4'hF, 1, 0, 1, 1, 4'b0010, 4'b0000, 1));
        vq.push_back(mk(0, 4'b0100, 4'hF, 1, 0, 1, 2, 4'b0100, 4'b0000, 1));
        vq.push_back(mk(0, 4'b0000, 4'h7, 0, 1, 0, 0, 4'b0000, 4'b1000, 0));
        vq.push_back(mk(0, 4'b0000, 4'h7, 0, 1, 0, 0, 4'b0000, 4'b1000, 0));
        vq.push_back(mk(0, 4'b0000, 4'hF, 0, 1, 0, 0, 4'b0000, 4'b1000, 1));
        vq.push_back(mk(0, 4'b0000, 4'hF, 0, 1, 0, 0, 4'b0000, 4'b0010, 1));
        vq.push_back(mk(0, 4'b0000, 4'hF, 0, 1, 0, 0, 4'b0000, 4'b0100, 1));
        vq.push_back(mk(0, 4'b0000, 4'hF, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
        vq.push_back(mk(1, 4'b0011, 4'hF, 1, 0, 1, 0, 4'b0001, 4'b0000, 1)); // reset mid-flight
        vq.push_back(mk(0, 4'b0010, 4'hF, 1, 0, 1, 1, 4'b0010, 4'b0000, 1));
        vq.push_back(mk(1, 4'b0000, 4'hF, 0, 1, 0, 0, 4'b0000, 4'b0000, 1));
        vq.push_back(mk(0, 4'b0011, 4'hF, 1, 0, 1, 0, 4'b0001, 4'b0000, 1));

        for (int n = 0; n < vq.size(); n++) apply(vq[n], n);

        // Steady push+pop at depth 3 walks both pointers past the wrap point.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(4'hF, 4'hF, 1'b1, 1'b0, 32'h0);
            chk("wrap_gnt", k, 64'(gmask()), 64'(4'b0001 << k));
        end
        for (int k = 0; k < 6; k++) begin
            drive(4'hF, 4'hF, 1'b1, 1'b1, 32'h0);
            chk("wrap_gnt", 3 + k, 64'(gmask()), 64'(4'b0001 << ((3 + k) % 4)));
            chk("wrap_rv", k, 64'(rvmask()), 64'(4'b0001 << (k % 4)));
        end
        drive(4'hF, 4'hF, 1'b1, 1'b0, 32'h0);
        chk("wrap_gnt", 9, 64'(gmask()), 64'(4'b0010));
        drive(4'hF, 4'hF, 1'b1, 1'b0, 32'h0);
        chk("wrap_full_req", 10, 64'(mgr_req.req), 64'(1'b0));
        chk("wrap_full_gnt", 10, 64'(gmask()), 64'(4'b0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
